// File: rtl/msp430_ram_mst_pkg.sv
// Shared constants and types for the msp430_ram_mst RAM initiator.
//   - Low-active RAM write-enable encodings per byte lane.
//   - Response buffer depth and entry layout.
//   - Write-enable selection helper.
package msp430_ram_mst_pkg;

    localparam logic [1:0] WEN_WORD = 2'b00;
    localparam logic [1:0] WEN_HI   = 2'b01;
    localparam logic [1:0] WEN_LO   = 2'b10;
    localparam logic [1:0] WEN_NONE = 2'b11;

    localparam int unsigned RSP_DEPTH = 3;
    localparam int unsigned RSP_W     = 17;
    localparam int unsigned RSP_CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } rsp_t;

    // Byte writes enable only the lane selected by address bit 0.
    function automatic logic [1:0] write_wen(input logic is_byte, input logic a0);
        if (!is_byte) begin
            return WEN_WORD;
        end
        return a0 ? WEN_HI : WEN_LO;
    endfunction

endpackage

// File: rtl/msp430_ram_mst_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (empties the FIFO)
//   i_push   write i_wdata (ignored when full)
//   i_wdata  entry to write
//   i_pop    drop the head entry (ignored when empty)
//   o_rdata  head entry
//   o_empty  no entries stored
//   o_count  number of entries stored
module msp430_ram_mst_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 17,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    assign w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_do_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/msp430_ram_mst.sv
// RAM initiator: turns a valid/ready byte-addressed request stream into cycles on a
// synchronous RAM (low-active chip enable and per-byte write enable, read data one
// cycle after the access) and returns one in-order response per request.
// Ports:
//   mclk, puc_rst             clock (also clocks the RAM) and synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we, req_byte          write / byte-access qualifiers
//   req_addr, req_wdata       byte address and write data
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        read data (0 for writes/errors) and out-of-range flag
//   ram_addr, ram_cen,
//   ram_wen, ram_din          RAM drive, valid in the accept cycle
//   ram_dout                  RAM read data, valid the cycle after a read access
module msp430_ram_mst
    import msp430_ram_mst_pkg::*;
#(
    parameter int unsigned ADDR_MSB = 6,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_MSB:0] ram_addr,
    output logic              ram_cen,
    output logic [1:0]        ram_wen,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);

    // In-flight stage: request accepted last cycle, RAM data arriving now.
    logic r_s1_valid;
    logic r_s1_we;
    logic r_s1_byte;
    logic r_s1_a0;
    logic r_s1_err;

    logic                 w_in_range;
    logic                 w_acc;
    logic                 w_access;
    logic [RSP_CNT_W:0]   w_credit_used;
    logic [RSP_CNT_W-1:0] w_fifo_count;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;
    rsp_t                 w_push_entry;
    rsp_t                 w_head;

    // Each accepted request holds a buffer slot from accept until its response pops,
    // so the buffer can never overflow even with rsp_ready held low.
    assign w_credit_used = (RSP_CNT_W + 1)'(w_fifo_count) + (RSP_CNT_W + 1)'(r_s1_valid);
    assign req_ready     = ~puc_rst & (w_credit_used < (RSP_CNT_W + 1)'(RSP_DEPTH));
    assign w_in_range    = {1'b0, req_addr} < MEM_LIMIT;
    assign w_acc         = req_valid & req_ready;
    assign w_access      = w_acc & w_in_range;

    always_comb begin
        ram_cen  = ~w_access;
        ram_wen  = WEN_NONE;
        ram_addr = '0;
        ram_din  = '0;
        if (w_access) begin
            ram_addr = req_addr[ADDR_MSB+1:1];
            if (req_we) begin
                ram_wen = write_wen(req_byte, req_addr[0]);
                ram_din = req_byte ? {2{req_wdata[7:0]}} : req_wdata;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_byte  <= 1'b0;
            r_s1_a0    <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_we   <= req_we;
                r_s1_byte <= req_byte;
                r_s1_a0   <= req_addr[0];
                r_s1_err  <= ~w_in_range;
            end
        end
    end

    always_comb begin
        w_push_entry.err   = r_s1_err;
        w_push_entry.rdata = '0;
        if (!r_s1_we && !r_s1_err) begin
            if (r_s1_byte) begin
                w_push_entry.rdata = r_s1_a0 ? {8'h00, ram_dout[15:8]} : {8'h00, ram_dout[7:0]};
            end else begin
                w_push_entry.rdata = ram_dout;
            end
        end
    end

    assign w_push = r_s1_valid;
    assign w_pop  = rsp_valid & rsp_ready;

    msp430_ram_mst_fifo #(
        .DEPTH(RSP_DEPTH),
        .WIDTH(RSP_W)
    ) u_fifo (
        .i_clk  (mclk),
        .i_rst  (puc_rst),
        .i_push (w_push),
        .i_wdata(w_push_entry),
        .i_pop  (w_pop),
        .o_rdata(w_head),
        .o_empty(w_fifo_empty),
        .o_count(w_fifo_count)
    );

    // Outputs are forced idle during reset so nothing stale is offered.
    assign rsp_valid = ~w_fifo_empty & ~puc_rst;
    assign rsp_rdata = rsp_valid ? w_head.rdata : '0;
    assign rsp_err   = rsp_valid ? w_head.err : 1'b0;

endmodule

// File: tb/tb_msp430_ram_mst.sv
module tb_msp430_ram_mst;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [6:0]  ram_addr;
    logic        ram_cen;
    logic [1:0]  ram_wen;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    msp430_ram_mst #(
        .ADDR_MSB(6),
        .MEM_SIZE(256)
    ) dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_byte (req_byte),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .ram_addr (ram_addr),
        .ram_cen  (ram_cen),
        .ram_wen  (ram_wen),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 mclk = ~mclk;

    // Synchronous RAM attached to the DUT.
    logic [15:0] ram_mem [128];
    always @(posedge mclk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) ram_mem[ram_addr][7:0] <= ram_din[7:0];
            if (!ram_wen[1]) ram_mem[ram_addr][15:8] <= ram_din[15:8];
            ram_dout <= ram_mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: byte memory updated at accept, queue of responses owed.
    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          rdy;
    } exp_t;
    exp_t        q[$];
    logic [7:0]  mm [256];
    logic [16:0] act_log[$];
    int          pop_cyc[$];
    logic [18:0] acc_log[$];
    int          acc_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge mclk) begin
        logic e_ready, e_acc, e_in, e_valid;
        logic [7:0] a;
        exp_t e;
        e_ready = !puc_rst && (q.size() < 3);
        chk("req_ready", req_ready, e_ready);
        e_acc = req_valid && e_ready;
        e_in  = req_addr < 16'd256;
        a     = req_addr[7:0];
        if (e_acc && e_in) begin
            chk("ram_cen_on", ram_cen, 0);
            chk("ram_addr", ram_addr, req_addr[7:1]);
            if (req_we && req_byte) begin
                chk("ram_wen_byte", ram_wen, a[0] ? 2'b01 : 2'b10);
                chk("ram_din_byte", ram_din, {req_wdata[7:0], req_wdata[7:0]});
            end else if (req_we) begin
                chk("ram_wen_word", ram_wen, 2'b00);
                chk("ram_din_word", ram_din, req_wdata);
            end else begin
                chk("ram_wen_read", ram_wen, 2'b11);
            end
        end else begin
            chk("ram_cen_off", ram_cen, 1);
            chk("ram_wen_off", ram_wen, 2'b11);
        end
        e_valid = !puc_rst && (q.size() > 0) && (q[0].rdy <= cyc);
        chk("rsp_valid", rsp_valid, e_valid);
        if (e_valid) begin
            chk("rsp_rdata", rsp_rdata, q[0].rdata);
            chk("rsp_err", rsp_err, q[0].err);
        end
        if (puc_rst) begin
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
        end
        chk("push_when_full", (dut.w_push && dut.w_fifo_count == 2'd3), 0);

        if (puc_rst) begin
            q.delete();
        end else begin
            if (e_valid && rsp_ready) begin
                act_log.push_back({rsp_err, rsp_rdata});
                pop_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (e_acc) begin
                e.err   = !e_in;
                e.rdata = 16'h0000;
                e.rdy   = cyc + 2;
                if (e_in && req_we) begin
                    if (req_byte) begin
                        mm[a] = req_wdata[7:0];
                    end else begin
                        mm[{a[7:1], 1'b0}] = req_wdata[7:0];
                        mm[{a[7:1], 1'b1}] = req_wdata[15:8];
                    end
                end else if (e_in) begin
                    if (req_byte) e.rdata = {8'h00, mm[a]};
                    else e.rdata = {mm[{a[7:1], 1'b1}], mm[{a[7:1], 1'b0}]};
                end
                acc_log.push_back({ram_cen, ram_wen, ram_din});
                acc_cyc.push_back(cyc);
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic clear_logs();
        act_log.delete();
        pop_cyc.delete();
        acc_log.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic issue(input logic we, input logic bt, input logic [15:0] a,
                         input logic [15:0] d);
        logic ok;
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bt;
        req_addr  = a;
        req_wdata = d;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge mclk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge mclk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int idx, nr;
        logic [15:0] bp_addr [5];

        repeat (2) @(posedge mclk);
        @(negedge mclk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_cen", ram_cen, 1);
        @(posedge mclk);
        #1;
        puc_rst = 1'b0;

        // Preload every RAM word so all later reads are defined.
        rsp_ready = 1'b1;
        for (int i = 0; i < 128; i++) issue(1'b1, 1'b0, 16'(i * 2), 16'($urandom));
        wait_cycles(5);

        // Word write then read-after-write.
        clear_logs();
        issue(1'b1, 1'b0, 16'h0010, 16'h1234);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000);
        wait_cycles(5);
        chk("t1_nacc", acc_log.size(), 2);
        chk("t1_nrsp", act_log.size(), 2);
        chk("t1_wr_drive", acc_log[0], {1'b0, 2'b00, 16'h1234});
        chk("t1_rd_drive", acc_log[1][18:16], 3'b011);
        chk("t1_wr_rsp", act_log[0], 17'h0_0000);
        chk("t1_rd_rsp", act_log[1], {1'b0, 16'h1234});
        chk("t1_latency", pop_cyc[1] - acc_cyc[1], 2);

        // Byte write into high lane, then word and byte reads.
        clear_logs();
        issue(1'b1, 1'b1, 16'h0011, 16'h00AB);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000);
        issue(1'b0, 1'b1, 16'h0010, 16'h0000);
        issue(1'b0, 1'b1, 16'h0011, 16'h0000);
        wait_cycles(5);
        chk("t2_nrsp", act_log.size(), 4);
        chk("t2_bw_drive", acc_log[0], {1'b0, 2'b01, 16'hABAB});
        chk("t2_word", act_log[1], {1'b0, 16'hAB34});
        chk("t2_byte_lo", act_log[2], {1'b0, 16'h0034});
        chk("t2_byte_hi", act_log[3], {1'b0, 16'h00AB});

        // Out of range.
        clear_logs();
        issue(1'b0, 1'b0, 16'h0100, 16'h0000);
        wait_cycles(5);
        chk("t3_cen", acc_log[0][18], 1);
        chk("t3_rsp", act_log[0], {1'b1, 16'h0000});

        // Backpressure: only three requests fit until responses drain.
        clear_logs();
        bp_addr = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};
        idx = 0;
        req_we = 1'b0;
        req_byte = 1'b0;
        for (int c = 0; c < 40; c++) begin
            req_valid = (idx < 5);
            req_addr  = bp_addr[(idx < 5) ? idx : 0];
            rsp_ready = (c >= 10);
            @(negedge mclk);
            if (c == 9) begin
                chk("t4_accepted", idx, 3);
                chk("t4_ready_low", req_ready, 0);
            end
            if (req_valid && req_ready) idx++;
            @(posedge mclk);
            #1;
        end
        req_valid = 1'b0;
        wait_cycles(5);
        chk("t4_total_acc", idx, 5);
        chk("t4_nrsp", act_log.size(), 5);
        chk("t4_first", act_log[0], {1'b0, 16'hAB34});

        // Full throughput.
        clear_logs();
        rsp_ready = 1'b1;
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_addr  = 16'(i * 2);
            @(negedge mclk);
            if (!req_ready) nr++;
            @(posedge mclk);
            #1;
        end
        req_valid = 1'b0;
        wait_cycles(5);
        chk("t5_never_stall", nr, 0);
        chk("t5_nrsp", act_log.size(), 8);
        chk("t5_consecutive", pop_cyc[7] - pop_cyc[0], 7);

        // Reset mid-stream.
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_addr  = 16'(i * 4);
            puc_rst   = (i == 4);
            @(negedge mclk);
            if (i == 4) begin
                chk("t6_rst_cen", ram_cen, 1);
                chk("t6_rst_valid", rsp_valid, 0);
            end
            if (i == 5) chk("t6_post_valid", rsp_valid, 0);
            @(posedge mclk);
            #1;
        end
        puc_rst = 1'b0;
        req_valid = 1'b0;
        wait_cycles(5);
        chk("t6_nrsp", act_log.size(), 7);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            puc_rst   = ($urandom_range(0, 199) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_byte  = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                                    : 16'($urandom_range(0, 255));
            req_wdata = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge mclk);
            #1;
        end
        puc_rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_cycles(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msp430_ram_mst.md
Name: msp430_ram_mst

Overview:
- Initiator for the scalable synchronous RAM port: chip-enable low active, 2-bit write-enable low active, registered read data one cycle after access.
- Converts a valid/ready byte-addressed request stream (CPU-side bench masters, DMA, test loaders) into RAM cycles.
- Returns one in-order response per request through a 3-entry response buffer with backpressure.
- Full throughput of one request per cycle while rsp_ready is held high.

Parameters:
- ADDR_MSB, 6, MSB of the RAM word address bus.
- MEM_SIZE, 256, RAM size in bytes; byte addresses >= MEM_SIZE are out of range.

Ports:
- mclk  in  1  clock; also drives the RAM clock.
- puc_rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  16  byte address.
- req_wdata  in  16  write data; bits [7:0] used for byte writes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  16  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.
- ram_addr  out  ADDR_MSB+1  RAM word address.
- ram_cen  out  1  RAM chip enable, low active.
- ram_wen  out  2  RAM write enable, low active, per byte.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data.

Behaviour:
- Clocking and reset: one clock mclk; reset puc_rst is synchronous, active-high.
- Reset values: req_ready=0 while puc_rst=1; rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_cen=1, ram_wen=2'b11.
- Reset mid-operation: in-flight stage and buffer are flushed, responses are discarded, and no RAM access occurs in the reset cycle.
- Accept: acc = req_valid & req_ready.
  - req_ready = ~puc_rst & (count + s1_valid < 3).
  - count is buffer occupancy; s1_valid is the in-flight stage.
- Address mapping:
  - ram_addr = req_addr[ADDR_MSB+1:1].
  - in_range = req_addr < MEM_SIZE.
  - Word accesses ignore req_addr[0].
- RAM drive (combinational in the accept cycle N):
  - ram_cen = ~(acc & in_range).
  - Word write: ram_wen=2'b00, ram_din=req_wdata.
  - Byte write with addr[0]=0: ram_wen=2'b10 (low lane).
  - Byte write with addr[0]=1: ram_wen=2'b01 (high lane).
  - Byte write data: ram_din={req_wdata[7:0],req_wdata[7:0]}.
  - Read: ram_wen=2'b11.
  - When not accessing: ram_wen=2'b11, and ram_addr/ram_din hold don't-care (drive 0).
- Stage s1 (registered at the end of N): stores s1_valid, we, byte, addr[0], err=~in_range.
- Cycle N+1: ram_dout is valid. The response is formed and pushed into the buffer at the end of N+1:
  - Word read: rdata=ram_dout.
  - Byte read: rdata = addr[0] ? {8'h00,ram_dout[15:8]} : {8'h00,ram_dout[7:0]}.
  - Write or err: rdata=16'h0000.
  - err=1 for out-of-range requests, with no RAM access.
- Latency: rsp_valid is asserted no earlier than N+2.
- Buffer:
  - 3-entry FIFO; rsp_* are driven from the head entry.
  - Push and pop in the same cycle are legal and leave count unchanged.
  - The credit rule guarantees a push never occurs when full; the bench asserts this.
- Ordering: strictly in order; exactly one response per accepted request.
- Read-after-write to the same address on back-to-back cycles returns the new data, because the RAM writes at the edge ending N.

Decomposition:
- Package msp430_ram_mst_pkg:
  - WEN_WORD=2'b00, WEN_HI=2'b01, WEN_LO=2'b10, WEN_NONE=2'b11.
  - FIFO depth constant RSP_DEPTH=3.
  - Response entry width constant (17 bits: err + data).
- Sub-module msp430_ram_mst_fifo:
  - Parameterised-depth synchronous FIFO with count output.
  - Synchronous active-high reset.

Test Plan:
- Word write 0x1234 @0x0010, then word read @0x0010 with rsp_ready=1 -> write rsp {rdata=0, err=0}, then read rsp rdata=0x1234 two cycles after accept; RAM sees ram_cen=0 with ram_wen=2'b00, then ram_wen=2'b11.
- Byte write 0xAB @0x0011 over word 0x1234 @0x0010, then word read -> rdata=0xAB34; ram_wen=2'b01 and ram_din=0xABAB during the byte write.
- Byte reads @0x0010 and @0x0011 after the above -> 0x0034, 0x00AB.
- Read @0x0100 with MEM_SIZE=256 -> ram_cen stays 1, rsp err=1, rdata=0.
- Backpressure: rsp_ready=0 and 5 reads issued -> exactly 3 accepted, then req_ready=0. Raising rsp_ready -> 5 in-order responses, no loss, no overflow.
- Throughput and reset: 8 back-to-back reads with rsp_ready=1 -> req_ready never deasserts, 8 responses on consecutive cycles. Asserting puc_rst for 1 cycle mid-stream -> rsp_valid=0 next cycle, ram_cen=1 during reset, and no stale responses afterwards.
